// File: rtl/cdc_capture_pkg.sv
`default_nettype none
// ============================================================================
// cdc_capture_pkg : state encoding and width helper for cdc_word_capture
// Rev 1.0
// ============================================================================
package cdc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// settle_timer : counts settle cycles after a toggle; done on the last one
// Rev 1.0
// ============================================================================
module settle_timer
  import cdc_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int C_CNT_W = clog2(SETTLE_CYCLES + 1);

  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == C_CNT_W'(SETTLE_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/cdc_word_capture.sv
`default_nettype none
// ============================================================================
// cdc_word_capture : toggle-handshake CDC receiver, settles then captures a
// word onto valid/ready. Option: CDC_CAPTURE_STABLE_CHECK_EN.
// Rev 1.0
// ============================================================================
module cdc_word_capture
  import cdc_capture_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int INIT_VALUE    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync_toggle,
  input  logic [WIDTH-1:0] sync_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             ack_toggle,
  input  logic             err_clear,
  output logic             err_overrun
);

  localparam logic [WIDTH-1:0] C_INIT = WIDTH'(INIT_VALUE);

  state_t           r_state, w_state_nxt;
  logic             r_last_toggle, w_last_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_valid, w_valid_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_err, w_err_nxt;
  logic             r_tog_prev;
  logic             w_edge, w_req, w_unstable;
  logic             w_tmr_clr, w_tmr_en, w_tmr_done;

  assign w_edge = sync_toggle ^ r_tog_prev;
  assign w_req  = sync_toggle != r_last_toggle;

`ifdef CDC_CAPTURE_STABLE_CHECK_EN
  logic [WIDTH-1:0] r_d_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_d_prev <= '0;
    else          r_d_prev <= sync_data;
  end

  assign w_unstable = (sync_data != r_d_prev);
`else
  assign w_unstable = 1'b0;
`endif

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .o_done (w_tmr_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_toggle;
    w_ack_nxt   = r_ack;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    w_err_nxt   = r_err;
    // A new request while busy sets the flag even if cleared the same cycle.
    if (err_clear) w_err_nxt = 1'b0;
    if (w_edge && (r_state != ST_IDLE)) w_err_nxt = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_SETTLE;
          w_tmr_clr   = 1'b1;
          w_last_nxt  = sync_toggle;
        end
      end
      ST_SETTLE: begin
        if (w_unstable) begin
          w_tmr_clr = 1'b1;
        end else if (w_tmr_done) begin
          w_data_nxt  = sync_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_valid && out_ready) begin
          w_valid_nxt = 1'b0;
          w_ack_nxt   = ~r_ack;
          if (w_req) begin
            w_state_nxt = ST_SETTLE;
            w_tmr_clr   = 1'b1;
            w_last_nxt  = sync_toggle;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_last_toggle <= 1'b0;
      r_ack         <= 1'b0;
      r_valid       <= 1'b0;
      r_data        <= C_INIT;
      r_err         <= 1'b0;
      r_tog_prev    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_toggle <= w_last_nxt;
      r_ack         <= w_ack_nxt;
      r_valid       <= w_valid_nxt;
      r_data        <= w_data_nxt;
      r_err         <= w_err_nxt;
      r_tog_prev    <= sync_toggle;
    end
  end

  assign out_valid   = r_valid;
  assign out_data    = r_data;
  assign ack_toggle  = r_ack;
  assign err_overrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdc_word_capture.sv
`default_nettype none
// ============================================================================
// tb_cdc_word_capture : scoreboard bench for cdc_word_capture
// Rev 1.0
// ============================================================================
module tb_cdc_word_capture;

`ifdef CDC_CAPTURE_STABLE_CHECK_EN
  localparam bit STABLE = 1'b1;
`else
  localparam bit STABLE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sync_toggle = 1'b0;
  logic [7:0] sync_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       ack_toggle;
  logic       err_overrun;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  logic       exp_ack = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  cdc_word_capture #(
    .WIDTH        (8),
    .SETTLE_CYCLES(2),
    .INIT_VALUE   (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_toggle(sync_toggle),
    .sync_data  (sync_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .ack_toggle (ack_toggle),
    .err_clear  (err_clear),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    sync_data   = w;
    sync_toggle = ~sync_toggle;
    sb.push_back(w);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: out_valid still 0 after %0d cycles, expected 1", budget);
    end
  endtask

  task automatic wait_ack(input int budget, input bit rnd_ready);
    int n = 0;
    while ((ack_toggle != sync_toggle) && n < budget) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    if (ack_toggle != sync_toggle) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ack: ack %0b after %0d cycles, expected %0b", ack_toggle, budget, sync_toggle);
    end
  endtask

  // Monitor: ack parity, hold stability and in-order word delivery.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_ack    = 1'b0;
        prev_valid = 1'b0;
      end else begin
        chk("ack_toggle", ack_toggle, exp_ack);
        if (out_valid && prev_valid) chk("hold_stable", out_data, prev_data);
        prev_valid = out_valid;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
          end else begin
            chk("word", out_data, sb.pop_front());
          end
          exp_ack = ~exp_ack;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ack", ack_toggle, 0);
    chk("rst_err", err_overrun, 0);
    reset_n = 1'b1;
    tick();

    // Basic transfer, latency of SETTLE_CYCLES edges.
    out_ready = 1'b1;
    send(8'hA5);
    tick();
    chk("basic_e0_valid", out_valid, 0);
    tick();
    chk("basic_e1_valid", out_valid, 0);
    tick();
    chk("basic_e2_valid", out_valid, 1);
    chk("basic_e2_data", out_data, 8'hA5);
    tick();
    chk("basic_ack", ack_toggle, 1);
    chk("basic_done_valid", out_valid, 0);
    tick();

    // Backpressure.
    out_ready = 1'b0;
    send(8'h3C);
    repeat (12) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h3C);
    chk("bp_ack_held", ack_toggle, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_ack_flip", ack_toggle, 0);
    chk("bp_valid_drop", out_valid, 0);
    tick();

    // Overrun: second flip during SETTLE, with a simultaneous clear.
    out_ready = 1'b0;
    send(8'h11);
    tick();
    chk("ovr_err_pre", err_overrun, 0);
    sync_toggle = ~sync_toggle;
    err_clear   = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovr_err_set_wins", err_overrun, 1);
    tick();
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_data", out_data, 8'h11);
    sync_data = 8'h22;
    sb.push_back(8'h22);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("ovr_ack", ack_toggle, 0);
    chk("ovr_drained", sb.size(), 0);
    chk("ovr_err_sticky", err_overrun, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovr_err_clear", err_overrun, 0);

    // Data changes one cycle into SETTLE.
    sync_data   = 8'h00;
    sync_toggle = ~sync_toggle;
    sb.push_back(8'hFF);
    tick();
    sync_data = 8'hFF;
    tick();
    tick();
    chk("stable_e2_valid", out_valid, STABLE ? 0 : 1);
    tick();
    chk("stable_e3_valid", out_valid, STABLE ? 1 : 0);
    repeat (3) tick();
    chk("stable_ack", ack_toggle, sync_toggle);

    // Back-to-back with source waiting for ack.
    for (int i = 0; i < 16; i++) begin
      wait_ack(40, 1'b1);
      w = 8'($urandom);
      send(w);
    end
    wait_ack(40, 1'b0);
    chk("b2b_err", err_overrun, 0);
    chk("b2b_drained", sb.size(), 0);

    // Asynchronous reset while a word is held.
    out_ready = 1'b0;
    send(8'h5A);
    wait_valid(20);
    #1;
    reset_n     = 1'b0;
    sb.delete();
    sync_toggle = 1'b0;
    sync_data   = 8'h00;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 8'h00);
    chk("midrst_ack", ack_toggle, 0);
    chk("midrst_err", err_overrun, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(8'h77);
    wait_ack(20, 1'b0);
    chk("recover_drained", sb.size(), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
